uart_rx_cfg: RTL and testbench
==============================

Name: uart_rx_cfg

Overview:
Parametrised UART receiver, next generation of the fixed 8E1 receiver. It supports configurable data width, parity mode and stop-bit count. It uses x16 oversampling with 3-sample majority voting and validates false starts. Received bytes leave through a ready/valid output with framing and overrun detection. It sits between the board RX pin and the command/FIFO logic.

Parameters:
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD_RATE, 115_200: line bit rate.
- OVERSAMPLE, 16: ticks per bit. Must be even and ≥8.
- DATA_BITS, 8: data bits per frame, 5–9.
- PARITY_MODE, 1: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: stop bits expected, 1 or 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- serial_in  in  1  asynchronous RX line; idles high.
- data_out  out  DATA_BITS  received word, LSB first on the line.
- data_valid  out  1  data_out and the error flags are valid. Held until accepted.
- data_ready  in  1  consumer accepts the word when data_valid && data_ready.
- parity_error  out  1  parity mismatch for the presented word. Always 0 when PARITY_MODE = 0.
- framing_error  out  1  a stop bit was sampled as 0 for the presented word.
- overrun_error  out  1  one-cycle pulse: a frame completed while the previous word was still unaccepted.

Behaviour:
- Reset: one clock; reset is synchronous and active-high.
  - On rst at a clk edge: state = IDLE; all counters = 0.
  - data_out, data_valid, parity_error, framing_error and overrun_error = 0.
  - The synchroniser flops are set to 1.
- Reset mid-frame aborts the frame with no output. The next frame is received normally.
- Input path: 2-flop synchroniser on serial_in. All logic uses the synchronised value.
- Tick: TICK_DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), integer-truncated. A tick is a one-cycle pulse every TICK_DIV clocks. The tick counter is cleared when entering START.
- Sampling: each bit uses ticks 0..OVERSAMPLE-1. Three samples are taken at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The bit value is the majority of the three.
- States:
  - IDLE: a synchronised 0 moves to START.
  - START: at the tick after the last start-bit sample, a majority of 1 means a false start → back to IDLE with no output. A majority of 0 goes to DATA.
  - DATA: shifts in DATA_BITS bits, LSB first. After the last bit, go to PARITY if PARITY_MODE ≠ 0, otherwise to STOP.
  - PARITY: compares the received bit against the XOR of the data bits (even mode) or its inverse (odd mode).
  - STOP: samples STOP_BITS bits. Any 0 sets the frame's framing flag. After the majority decision of the last stop bit, go directly to IDLE. There is no wait for end of bit, so back-to-back frames resynchronise.
- Completion: one clk after the last stop-bit decision:
  - If data_valid = 0, or data_ready = 1 in that same cycle: load data_out and both error flags, then set data_valid = 1.
  - Otherwise: discard the new frame, keep the old word, and pulse overrun_error for one cycle.
- Handshake: data_valid falls the cycle after data_valid && data_ready, unless a new word loads in that same cycle (simultaneous accept and load, as above).
- A framing-error word is still presented. A line held low (break) yields a word 0 with framing_error = 1, then the block waits in IDLE only after the line returns high. IDLE requires a 1 to have been seen since the last STOP.
- Arithmetic: counters are sized with $clog2. The tick counter wraps at TICK_DIV-1. The sample counter wraps at OVERSAMPLE-1.

Decomposition:
- Package uart_pkg holds:
  - the PARITY_NONE/EVEN/ODD constants;
  - the state encoding (IDLE, START, DATA, PARITY, STOP);
  - a function computing TICK_DIV.
- Sub-module uart_os_tick: parametrised tick generator with a clear input, reusable by a future TX.

Test Plan:
- Bench parameters: CLK_FREQ = 1_600_000, BAUD_RATE = 100_000 (TICK_DIV = 1, 16 clocks per bit), data_ready held 1.
- Send 0x55 with parity bit 0 (even) → data_out = 0x55, data_valid high, parity_error = 0, framing_error = 0.
- Send 0xA7 with an inverted parity bit → data_out = 0xA7, parity_error = 1.
- Send 0x3C with stop bit 0 → data_out = 0x3C, framing_error = 1. The next frame 0x12 is received cleanly.
- 3-clock low glitch on serial_in → no data_valid. A following frame 0x81 is received correctly.
- data_ready = 0, send 0x11 then 0x22 → data_out stays 0x11 and overrun_error pulses once. Then raise data_ready → data_valid drops the next cycle.
- Assert rst during data bit 4 of a frame → no output. Then DATA_BITS = 7, PARITY_MODE = 0, STOP_BITS = 2, send 0x5A → data_out = 0x5A with no errors.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, state encoding and helpers for the UART receiver
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  function automatic int calc_tick_div(input int clk_freq, input int baud_rate, input int oversample);
    return clk_freq / (baud_rate * oversample);
  endfunction

  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_os_tick.sv
// rtl/uart_os_tick.sv - oversampling tick generator: one-cycle pulse every DIV clocks, restartable
module uart_os_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - configurable oversampling UART receiver with ready/valid output
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int BAUD_RATE   = 115_200,
  parameter int OVERSAMPLE  = 16,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 overrun_error
);

  localparam int TICK_DIV = calc_tick_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_A    = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_B    = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_C    = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_DEC  = SW'(OVERSAMPLE / 2 + 2);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  rx_state_t state, state_nxt;

  logic                 sync1, rxd;
  logic                 tick, tick_clr;
  logic [SW-1:0]        s_cnt;
  logic [2:0]           samp;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr_q, ferr_q, seen_high, done;
  logic                 decide, bit_val, last_stop;

  uart_os_tick #(.DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (tick_clr),
    .tick  (tick)
  );

  // Decisions fall one tick after the third sample so the vote includes all three.
  assign decide    = tick && (s_cnt == S_DEC);
  assign bit_val   = majority3(samp);
  assign tick_clr  = (state == IDLE) && seen_high && !rxd;
  assign last_stop = (state == STOP) && decide && (bit_cnt == STOP_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (seen_high && !rxd) state_nxt = START;
      START:   if (decide) state_nxt = bit_val ? IDLE : DATA;
      DATA:    if (decide && (bit_cnt == DATA_LAST))
                 state_nxt = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
      PARITY:  if (decide) state_nxt = STOP;
      STOP:    if (decide && (bit_cnt == STOP_LAST)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= 1'b1;
      rxd       <= 1'b1;
      s_cnt     <= '0;
      samp      <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      seen_high <= 1'b0;
      done      <= 1'b0;
    end else begin
      sync1 <= serial_in;
      rxd   <= sync1;
      done  <= 1'b0;

      // A break leaves the line low after STOP; demand a high before re-arming.
      if (last_stop) begin
        seen_high <= 1'b0;
      end else if (rxd) begin
        seen_high <= 1'b1;
      end

      if (tick_clr) begin
        s_cnt   <= '0;
        bit_cnt <= '0;
        perr_q  <= 1'b0;
        ferr_q  <= 1'b0;
      end else if (state != IDLE && tick) begin
        s_cnt <= (s_cnt == S_LAST) ? '0 : s_cnt + SW'(1);
        if (s_cnt == S_A || s_cnt == S_B || s_cnt == S_C) begin
          samp <= {samp[1:0], rxd};
        end
      end

      if (decide) begin
        case (state)
          DATA: begin
            shreg   <= {bit_val, shreg[DATA_BITS-1:1]};
            bit_cnt <= (bit_cnt == DATA_LAST) ? '0 : bit_cnt + BW'(1);
          end
          PARITY: begin
            if (PARITY_MODE == PARITY_ODD) begin
              perr_q <= (bit_val == ^shreg);
            end else begin
              perr_q <= (bit_val != ^shreg);
            end
          end
          STOP: begin
            if (!bit_val) ferr_q <= 1'b1;
            bit_cnt <= (bit_cnt == STOP_LAST) ? '0 : bit_cnt + BW'(1);
            if (bit_cnt == STOP_LAST) done <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // The framing flag is taken from ferr_q, which already holds the final stop vote.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out      <= '0;
      data_valid    <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      overrun_error <= 1'b0;
      if (done) begin
        if (!data_valid || data_ready) begin
          data_out      <= shreg;
          parity_error  <= perr_q;
          framing_error <= ferr_q;
          data_valid    <= 1'b1;
        end else begin
          overrun_error <= 1'b1;
        end
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - self-checking bench: 8E1 and 7N2 receivers against a frame-level model
module tb_uart_rx_cfg;

  localparam int BIT = 16;

  typedef struct packed {
    logic [8:0] d;
    logic       pe;
    logic       fe;
  } word_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx0 = 1'b1, rx1 = 1'b1;
  logic       dr0 = 1'b1, dr1 = 1'b1;
  logic [7:0] do0;
  logic [6:0] do1;
  logic       dv0, pe0, fe0, ov0;
  logic       dv1, pe1, fe1, ov1;

  int checks = 0;
  int errors = 0;
  word_t got0[$];
  word_t got1[$];
  int ovr0 = 0;

  always #5 clk = ~clk;

  uart_rx_cfg #(
    .CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .OVERSAMPLE(16),
    .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)
  ) dut (
    .clk(clk), .rst(rst), .serial_in(rx0), .data_out(do0), .data_valid(dv0),
    .data_ready(dr0), .parity_error(pe0), .framing_error(fe0), .overrun_error(ov0)
  );

  uart_rx_cfg #(
    .CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .OVERSAMPLE(16),
    .DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2)
  ) dut2 (
    .clk(clk), .rst(rst), .serial_in(rx1), .data_out(do1), .data_valid(dv1),
    .data_ready(dr1), .parity_error(pe1), .framing_error(fe1), .overrun_error(ov1)
  );

  // Post-edge view: a valid&&ready pair seen here is consumed at the next edge.
  always @(posedge clk) begin
    #1;
    if (dv0 && dr0) got0.push_back({1'b0, do0, pe0, fe0});
    if (dv1 && dr1) got1.push_back({2'b0, do1, pe1, fe1});
    if (ov0) ovr0++;
  end

  task automatic drive(input int which, input logic b, input int ncyc);
    if (which == 0) rx0 = b; else rx1 = b;
    repeat (ncyc) @(negedge clk);
  endtask

  task automatic send_frame(input int which, input logic [8:0] data, input int nbits,
                            input int pmode, input bit pflip, input int nstop,
                            input logic [1:0] stops);
    int ones;
    ones = 0;
    drive(which, 1'b0, BIT);
    for (int i = 0; i < nbits; i++) begin
      ones += int'(data[i]);
      drive(which, data[i], BIT);
    end
    if (pmode != 0) drive(which, logic'((ones % 2) ^ (pmode == 2) ^ pflip), BIT);
    for (int i = 0; i < nstop; i++) drive(which, stops[i], BIT);
    drive(which, 1'b1, 2 * BIT);
  endtask

  function automatic word_t model(input logic [8:0] data, input int nbits, input int pmode,
                                  input bit pflip, input int nstop, input logic [1:0] stops);
    word_t w;
    int ones, pbit;
    ones = 0;
    for (int i = 0; i < nbits; i++) ones += int'(data[i]);
    pbit = (ones % 2) ^ int'(pmode == 2) ^ int'(pflip);
    w.d  = data;
    w.pe = (pmode != 0) && (((ones + pbit) % 2) != ((pmode == 2) ? 1 : 0));
    w.fe = 1'b0;
    for (int i = 0; i < nstop; i++) if (stops[i] == 1'b0) w.fe = 1'b1;
    return w;
  endfunction

  task automatic get_word(input int which, output word_t w, output bit ok);
    ok = 1'b0;
    w  = '0;
    for (int i = 0; i < 400; i++) begin
      if (which == 0 && got0.size() > 0) begin w = got0.pop_front(); ok = 1'b1; break; end
      if (which == 1 && got1.size() > 0) begin w = got1.pop_front(); ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic expect_word(input int which, input word_t exp, input string name);
    word_t w;
    bit ok;
    get_word(which, w, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: no word received, expected d=%h pe=%b fe=%b", name, exp.d, exp.pe, exp.fe);
    end else if (w !== exp) begin
      errors++;
      $display("FAIL %s: got d=%h pe=%b fe=%b expected d=%h pe=%b fe=%b",
               name, w.d, w.pe, w.fe, exp.d, exp.pe, exp.fe);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({dv0, do0, pe0, fe0, ov0} !== 12'h0) begin
      errors++;
      $display("FAIL reset_dut: got %h expected 000", {dv0, do0, pe0, fe0, ov0});
    end
    checks++;
    if ({dv1, do1, pe1, fe1, ov1} !== 11'h0) begin
      errors++;
      $display("FAIL reset_dut2: got %h expected 000", {dv1, do1, pe1, fe1, ov1});
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_parity;
    send_frame(0, 9'h055, 8, 1, 1'b0, 1, 2'b11);
    expect_word(0, model(9'h055, 8, 1, 1'b0, 1, 2'b11), "even_0x55");
    send_frame(0, 9'h0A7, 8, 1, 1'b1, 1, 2'b11);
    expect_word(0, {9'h0A7, 1'b1, 1'b0}, "bad_parity_0xA7");
  endtask

  task automatic test_framing;
    send_frame(0, 9'h03C, 8, 1, 1'b0, 1, 2'b00);
    expect_word(0, {9'h03C, 1'b0, 1'b1}, "framing_0x3C");
    send_frame(0, 9'h012, 8, 1, 1'b0, 1, 2'b11);
    expect_word(0, {9'h012, 1'b0, 1'b0}, "after_framing_0x12");
  endtask

  task automatic test_glitch;
    drive(0, 1'b0, 3);
    drive(0, 1'b1, 40);
    checks++;
    if (got0.size() != 0 || dv0 !== 1'b0) begin
      errors++;
      $display("FAIL glitch: got %0d words dv=%b expected 0 words dv=0", got0.size(), dv0);
    end
    send_frame(0, 9'h081, 8, 1, 1'b0, 1, 2'b11);
    expect_word(0, {9'h081, 1'b0, 1'b0}, "after_glitch_0x81");
  endtask

  task automatic test_break;
    drive(0, 1'b0, 13 * BIT);
    drive(0, 1'b1, 2 * BIT);
    expect_word(0, {9'h000, 1'b0, 1'b1}, "break_word");
    checks++;
    if (got0.size() != 0) begin
      errors++;
      $display("FAIL break_extra: got %0d extra words expected 0", got0.size());
    end
    send_frame(0, 9'h0C3, 8, 1, 1'b0, 1, 2'b11);
    expect_word(0, {9'h0C3, 1'b0, 1'b0}, "after_break_0xC3");
  endtask

  task automatic test_overrun;
    dr0  = 1'b0;
    ovr0 = 0;
    send_frame(0, 9'h011, 8, 1, 1'b0, 1, 2'b11);
    send_frame(0, 9'h022, 8, 1, 1'b0, 1, 2'b11);
    checks++;
    if (do0 !== 8'h11 || dv0 !== 1'b1) begin
      errors++;
      $display("FAIL overrun_hold: got d=%h dv=%b expected d=11 dv=1", do0, dv0);
    end
    checks++;
    if (ovr0 != 1) begin
      errors++;
      $display("FAIL overrun_pulse: got %0d pulses expected 1", ovr0);
    end
    dr0 = 1'b1;
    @(negedge clk);
    checks++;
    if (dv0 !== 1'b0) begin
      errors++;
      $display("FAIL overrun_accept: got dv=%b expected 0", dv0);
    end
    got0.delete();
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] d;
    d = 8'hF1;
    drive(0, 1'b0, BIT);
    for (int i = 0; i < 4; i++) drive(0, d[i], BIT);
    drive(0, d[4], 8);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(0, d[4], 7);
    for (int i = 5; i < 8; i++) drive(0, d[i], BIT);
    drive(0, 1'b1, BIT);
    drive(0, 1'b1, 3 * BIT);
    checks++;
    if (got0.size() != 0 || dv0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort: got %0d words dv=%b expected 0 words dv=0", got0.size(), dv0);
    end
    send_frame(0, 9'h012, 8, 1, 1'b0, 1, 2'b11);
    expect_word(0, {9'h012, 1'b0, 1'b0}, "after_reset_0x12");
    send_frame(1, 9'h05A, 7, 0, 1'b0, 2, 2'b11);
    expect_word(1, {9'h05A, 1'b0, 1'b0}, "cfg7n2_0x5A");
  endtask

  task automatic test_random;
    logic [8:0] d;
    bit         pf;
    logic [1:0] st;
    for (int n = 0; n < 16; n++) begin
      d  = {1'b0, 8'($urandom_range(0, 255))};
      pf = ($urandom_range(0, 3) == 0);
      st = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b11;
      send_frame(0, d, 8, 1, pf, 1, st);
      expect_word(0, model(d, 8, 1, pf, 1, st), "random_8e1");
    end
    for (int n = 0; n < 10; n++) begin
      d  = {2'b0, 7'($urandom_range(0, 127))};
      st = 2'($urandom_range(0, 3));
      send_frame(1, d, 7, 0, 1'b0, 2, st);
      expect_word(1, model(d, 7, 0, 1'b0, 2, st), "random_7n2");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset;
    test_parity;
    test_framing;
    test_glitch;
    test_break;
    test_overrun;
    test_reset_mid_frame;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
